// File: rtl/rtc_set_ctrl.sv
`timescale 1ns/1ps
// RTC time-set FSM: shadows live BCD time, edits h/m/s with buttons, requests a load; outputs registered (1 cycle).
// Holds load_req until load_ack (no timeout in LOAD); define RTC_ALARM_EN to add the alarm-time editor and alarm pulse.
module rtc_set_ctrl #(
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hrm,
    input  logic [3:0] cur_hrl,
    input  logic [3:0] cur_minm,
    input  logic [3:0] cur_minl,
    input  logic [3:0] cur_secm,
    input  logic [3:0] cur_secl,
    output logic [3:0] set_hrm,
    output logic [3:0] set_hrl,
    output logic [3:0] set_minm,
    output logic [3:0] set_minl,
    output logic [3:0] set_secm,
    output logic [3:0] set_secl,
    output logic       load_req,
    input  logic       load_ack,
    output logic [2:0] mode,
    output logic       blink
`ifdef RTC_ALARM_EN
    ,
    output logic [3:0] al_hrm,
    output logic [3:0] al_hrl,
    output logic [3:0] al_minm,
    output logic [3:0] al_minl,
    output logic       alarm
`endif
);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        SET_HR     = 3'd1,
        SET_MIN    = 3'd2,
        SET_SEC    = 3'd3,
        LOAD       = 3'd4,
        SET_AL_HR  = 3'd5,
        SET_AL_MIN = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_S - 1);

    state_t     state_q, state_d;
    logic [7:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic [7:0] tmo_q, tmo_d;
    logic       blink_q, blink_d;
    logic       load_req_q, load_req_d;
    logic [7:0] cur_hr, cur_min, cur_sec;
    logic       in_set;
`ifdef RTC_ALARM_EN
    logic [7:0] al_hr_q, al_hr_d, al_min_q, al_min_d;
    logic       alarm_q, alarm_d;
`endif

    // Two-digit BCD increment that wraps to 00 after `top`; never carries out.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign cur_hr  = {cur_hrm, cur_hrl};
    assign cur_min = {cur_minm, cur_minl};
    assign cur_sec = {cur_secm, cur_secl};

    always_comb begin
        state_d    = state_q;
        hr_d       = hr_q;
        min_d      = min_q;
        sec_d      = sec_q;
        tmo_d      = tmo_q;
        blink_d    = blink_q;
        load_req_d = load_req_q;
`ifdef RTC_ALARM_EN
        al_hr_d  = al_hr_q;
        al_min_d = al_min_q;
        alarm_d  = (state_q == RUN) && tick_1hz && (cur_hr == al_hr_q)
                   && (cur_min == al_min_q) && (cur_sec == 8'h00);
        in_set   = (state_q inside {SET_HR, SET_MIN, SET_SEC, SET_AL_HR, SET_AL_MIN});
`else
        in_set   = (state_q inside {SET_HR, SET_MIN, SET_SEC});
`endif

        if (in_set) begin
            if (btn_mode || btn_inc) tmo_d = 8'd0;
            else if (tick_1hz)       tmo_d = tmo_q + 8'd1;
            if (tick_1hz) blink_d = ~blink_q;
        end

        case (state_q)
            RUN: begin
                hr_d       = cur_hr;
                min_d      = cur_min;
                sec_d      = cur_sec;
                tmo_d      = 8'd0;
                blink_d    = 1'b0;
                load_req_d = 1'b0;
                if (btn_mode) begin
                    state_d = SET_HR;
                    blink_d = 1'b1;
                end
`ifdef RTC_ALARM_EN
                else if (btn_inc) begin
                    state_d = SET_AL_HR;
                    blink_d = 1'b1;
                end
`endif
            end
            SET_HR: begin
                if (btn_mode)     state_d = SET_MIN;
                else if (btn_inc) hr_d = bcd_inc(hr_q, 8'h23);
            end
            SET_MIN: begin
                if (btn_mode)     state_d = SET_SEC;
                else if (btn_inc) min_d = bcd_inc(min_q, 8'h59);
            end
            SET_SEC: begin
                if (btn_mode) begin
                    state_d    = LOAD;
                    load_req_d = 1'b1;
                    blink_d    = 1'b0;
                end else if (btn_inc) begin
                    sec_d = bcd_inc(sec_q, 8'h59);
                end
            end
            LOAD: begin
                load_req_d = 1'b1;
                blink_d    = 1'b0;
                tmo_d      = 8'd0;
                if (load_ack) begin
                    state_d    = RUN;
                    load_req_d = 1'b0;
                end
            end
`ifdef RTC_ALARM_EN
            SET_AL_HR: begin
                if (btn_mode)     state_d = SET_AL_MIN;
                else if (btn_inc) al_hr_d = bcd_inc(al_hr_q, 8'h23);
            end
            SET_AL_MIN: begin
                if (btn_mode) begin
                    state_d = RUN;
                    blink_d = 1'b0;
                end else if (btn_inc) begin
                    al_min_d = bcd_inc(al_min_q, 8'h59);
                end
            end
`endif
            default: state_d = RUN;
        endcase

        // Abandon the session silently; shadow and alarm edits are simply left as-is.
        if (in_set && !btn_mode && !btn_inc && tick_1hz && (tmo_q == TMO_LAST)) begin
            state_d    = RUN;
            tmo_d      = 8'd0;
            blink_d    = 1'b0;
            load_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            hr_q       <= 8'h00;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            tmo_q      <= 8'd0;
            blink_q    <= 1'b0;
            load_req_q <= 1'b0;
`ifdef RTC_ALARM_EN
            al_hr_q    <= 8'h00;
            al_min_q   <= 8'h00;
            alarm_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hr_q       <= hr_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            tmo_q      <= tmo_d;
            blink_q    <= blink_d;
            load_req_q <= load_req_d;
`ifdef RTC_ALARM_EN
            al_hr_q    <= al_hr_d;
            al_min_q   <= al_min_d;
            alarm_q    <= alarm_d;
`endif
        end
    end

    assign {set_hrm, set_hrl}   = hr_q;
    assign {set_minm, set_minl} = min_q;
    assign {set_secm, set_secl} = sec_q;
    assign load_req = load_req_q;
    assign blink    = blink_q;
    assign mode     = state_q;
`ifdef RTC_ALARM_EN
    assign {al_hrm, al_hrl}   = al_hr_q;
    assign {al_minm, al_minl} = al_min_q;
    assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_rtc_set_ctrl.sv
`timescale 1ns/1ps
// Directed bench for rtc_set_ctrl: stimulus pushes expected outputs into a scoreboard, a monitor compares each cycle.
module tb_rtc_set_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, btn_mode, btn_inc, load_ack;
    logic [3:0] cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl;
    logic [3:0] set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl;
    logic       load_req, blink;
    logic [2:0] mode;
`ifdef RTC_ALARM_EN
    logic [3:0] al_hrm, al_hrl, al_minm, al_minl;
    logic       alarm;
`endif

    always #5 clk = ~clk;

    rtc_set_ctrl #(.TIMEOUT_S(30)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hrm(cur_hrm), .cur_hrl(cur_hrl), .cur_minm(cur_minm),
        .cur_minl(cur_minl), .cur_secm(cur_secm), .cur_secl(cur_secl),
        .set_hrm(set_hrm), .set_hrl(set_hrl), .set_minm(set_minm),
        .set_minl(set_minl), .set_secm(set_secm), .set_secl(set_secl),
        .load_req(load_req), .load_ack(load_ack), .mode(mode), .blink(blink)
`ifdef RTC_ALARM_EN
        , .al_hrm(al_hrm), .al_hrl(al_hrl), .al_minm(al_minm), .al_minl(al_minl),
        .alarm(alarm)
`endif
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [2:0]  mode;
        logic [23:0] set;
        logic        lr;
        logic        bl;
        bit          chk_bl;
        logic        al;
    } exp_t;

    exp_t sb[$];
    int   ncyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    wire [23:0] set_all = {set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl};

    // Monitor: outputs settle after each posedge; compare whatever was queued for that edge.
    initial begin
        forever begin
            @(posedge clk);
            ncyc++;
            #2;
            while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
                exp_t e;
                logic act_al;
                e = sb.pop_front();
`ifdef RTC_ALARM_EN
                act_al = alarm;
`else
                act_al = 1'b0;
`endif
                n_tests++;
                if (e.cyc != ncyc || mode !== e.mode || set_all !== e.set || load_req !== e.lr
                    || (e.chk_bl && blink !== e.bl) || act_al !== e.al) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got mode=%0d set=%06h load_req=%b blink=%b alarm=%b, want mode=%0d set=%06h load_req=%b blink=%b(chk=%0d) alarm=%b (due cyc %0d)",
                             e.name, ncyc, mode, set_all, load_req, blink, act_al,
                             e.mode, e.set, e.lr, e.bl, e.chk_bl, e.al, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic r, input logic m, input logic i, input logic t, input logic a);
        rst = r; btn_mode = m; btn_inc = i; tick_1hz = t; load_ack = a;
    endtask

    task automatic set_cur(input logic [23:0] v);
        {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl} = v;
    endtask

    task automatic expect_next(input string name, input logic [2:0] md, input logic [23:0] st,
                               input logic lr, input logic bl, input bit cb, input logic al = 1'b0);
        exp_t e;
        e.cyc = ncyc + 1; e.name = name; e.mode = md; e.set = st;
        e.lr = lr; e.bl = bl; e.chk_bl = cb; e.al = al;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        set_cur(24'h123456);
        drive(1, 0, 0, 0, 0);
        expect_next("reset", 3'd0, 24'h000000, 0, 0, 1);
        step();

        expect_next("run_follow", 3'd0, 24'h123456, 0, 0, 1);
        step();
        set_cur(24'h123457);
        expect_next("run_follow_latency", 3'd0, 24'h123457, 0, 0, 1);
        step();
        set_cur(24'h123456);
`ifndef RTC_ALARM_EN
        drive(0, 0, 1, 0, 0);
        expect_next("run_inc_ignored", 3'd0, 24'h123456, 0, 0, 1);
        step();
`endif

        drive(0, 1, 0, 0, 0);
        expect_next("enter_set_hr", 3'd1, 24'h123456, 0, 1, 1);
        step();
        set_cur(24'h222222);
        for (int k = 1; k <= 13; k++) begin
            drive(0, 0, 1, 0, 0);
            if (k == 11) expect_next("hr_23", 3'd1, 24'h233456, 0, 1, 1);
            if (k == 12) expect_next("hr_wrap_00", 3'd1, 24'h003456, 0, 1, 1);
            if (k == 13) expect_next("hr_01", 3'd1, 24'h013456, 0, 1, 1);
            step();
        end
        drive(0, 0, 0, 1, 0);
        expect_next("blink_toggle_0", 3'd1, 24'h013456, 0, 0, 1);
        step();
        drive(0, 0, 0, 1, 0);
        expect_next("blink_toggle_1", 3'd1, 24'h013456, 0, 1, 1);
        step();

        drive(0, 1, 0, 0, 0);
        expect_next("enter_set_min", 3'd2, 24'h013456, 0, 1, 1);
        step();
        for (int k = 1; k <= 25; k++) begin
            drive(0, 0, 1, 0, 0);
            if (k == 25) expect_next("min_59", 3'd2, 24'h015956, 0, 1, 1);
            step();
        end
        drive(0, 0, 1, 0, 0);
        expect_next("min_wrap_no_carry", 3'd2, 24'h010056, 0, 1, 1);
        step();
        drive(0, 1, 1, 0, 0);
        expect_next("mode_beats_inc", 3'd3, 24'h010056, 0, 1, 1);
        step();
        drive(0, 0, 1, 0, 0);
        expect_next("sec_inc", 3'd3, 24'h010057, 0, 1, 1);
        step();
        drive(0, 1, 0, 0, 0);
        expect_next("enter_load", 3'd4, 24'h010057, 1, 0, 1);
        step();
        for (int k = 0; k < 5; k++) begin
            set_cur(24'h100000 + 24'(k));
            drive(0, k == 1, k == 2, k == 3, 0);
            expect_next("load_hold", 3'd4, 24'h010057, 1, 0, 1);
            step();
        end
        drive(0, 0, 0, 0, 1);
        expect_next("load_ack_to_run", 3'd0, 24'h010057, 0, 0, 1);
        step();
        set_cur(24'h123456);
        expect_next("run_after_load", 3'd0, 24'h123456, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        expect_next("ack_in_run_ignored", 3'd0, 24'h123456, 0, 0, 1);
        step();

        drive(0, 1, 0, 0, 0);
        expect_next("tmo_enter_hr", 3'd1, 24'h123456, 0, 1, 1);
        step();
        drive(0, 1, 0, 0, 0);
        expect_next("tmo_enter_min", 3'd2, 24'h123456, 0, 1, 1);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 1, 0);
            step();
        end
        drive(0, 0, 1, 0, 0);
        expect_next("tmo_restart_inc", 3'd2, 24'h123556, 0, 1, 1);
        step();
        for (int k = 1; k <= 30; k++) begin
            drive(0, 0, 0, 1, 0);
            if (k < 30) expect_next("tmo_not_yet", 3'd2, 24'h123556, 0, 0, 0);
            else        expect_next("timeout_at_30", 3'd0, 24'h123556, 0, 0, 1);
            step();
        end
        expect_next("run_after_timeout", 3'd0, 24'h123456, 0, 0, 1);
        step();

        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 0, 0, 0);
            if (k == 4) expect_next("load_before_rst", 3'd4, 24'h123456, 1, 0, 1);
            step();
        end
        drive(1, 1, 1, 1, 1);
        expect_next("rst_in_load", 3'd0, 24'h000000, 0, 0, 1);
        step();
        expect_next("run_after_rst", 3'd0, 24'h123456, 0, 0, 1);
        step();

`ifdef RTC_ALARM_EN
        drive(0, 0, 1, 0, 0);
        expect_next("enter_al_hr", 3'd5, 24'h123456, 0, 1, 1);
        step();
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, 1, 0, 0);
            step();
        end
        drive(0, 1, 0, 0, 0);
        expect_next("enter_al_min", 3'd6, 24'h123456, 0, 1, 1);
        step();
        for (int k = 0; k < 15; k++) begin
            drive(0, 0, 1, 0, 0);
            step();
        end
        drive(0, 1, 0, 0, 0);
        expect_next("al_back_to_run", 3'd0, 24'h123456, 0, 0, 1);
        step();
        set_cur(24'h071500);
        expect_next("alarm_no_tick", 3'd0, 24'h071500, 0, 0, 1, 1'b0);
        step();
        drive(0, 0, 0, 1, 0);
        expect_next("alarm_pulse", 3'd0, 24'h071500, 0, 0, 1, 1'b1);
        step();
        expect_next("alarm_one_cycle", 3'd0, 24'h071500, 0, 0, 1, 1'b0);
        step();
`endif

        step();
        step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
